// File: rtl/inst_fetch_buf_if.sv
// inst_fetch_buf_if: bundle of the fetch stage's memory, control and pipeline signals.
// master = the fetch/buffer stage, slave = its environment (memory, redirect source, pipeline).
//
// Handshake rules:
//   - imem request moves when imem_req_valid && imem_req_ready are both high at a rising edge.
//     imem_req_valid and imem_req_addr depend only on registered state and redirect_valid/rst.
//   - imem_resp_valid has no ready. Responses come back in request order, one per cycle at most.
//   - redirect_valid is a one-cycle command with no handshake. halt is a level.
//   - inst/inst_pc/inst_valid are registered and present one value every cycle. No back-pressure.
interface inst_fetch_buf_if #(
  parameter int ADDR_W = 8
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_resp_valid;
  logic [7:0]        imem_resp_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic [7:0]        inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;

  modport master (
    output imem_req_valid, imem_req_addr, inst, inst_pc, inst_valid,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst, inst_pc, inst_valid,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, halt
  );
endinterface

// File: rtl/inst_fetch_buf.sv
// inst_fetch_buf: PC walker, in-order instruction memory requester and response FIFO.
// It feeds one 8-bit instruction per cycle to the pipeline and inserts NOP bubbles as needed.
// Optional feature: define IFETCH_BYPASS_EN so a response that finds the FIFO empty goes
// straight to inst. That gives 1-edge latency instead of 2.
// Reset: rst is synchronous and active-high.
module inst_fetch_buf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  inst_fetch_buf_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  // Architectural and bookkeeping state
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]     in_flight_q, in_flight_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     tag_wr_q, tag_wr_d;
  logic [PW-1:0]     tag_rd_q, tag_rd_d;
  logic [7:0]        inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;

  // Storage: response FIFO {data, pc} and in-order address tags of outstanding requests
  logic [7:0]        fifo_data_q [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
  logic [ADDR_W-1:0] tag_q       [DEPTH];

  // Per-cycle control
  logic [CW:0]       credit_sum;
  logic              req_valid;
  logic              req_fire;
  logic              resp_fire;
  logic              fifo_empty;
  logic              drop_now;
  logic              pop;
  logic              push;
  logic              bypass;
  logic [ADDR_W-1:0] resp_pc;

  // Credits count FIFO slots already spoken for by buffered and outstanding data
  assign credit_sum = {1'b0, fifo_cnt_q} + {1'b0, in_flight_q};
  assign req_valid  = !rst && !bus.redirect_valid && (credit_sum < DEPTH_C);
  assign req_fire   = req_valid && bus.imem_req_ready;
  assign resp_fire  = bus.imem_resp_valid;
  assign fifo_empty = (fifo_cnt_q == '0);
  assign drop_now   = (drop_cnt_q != '0);
  assign resp_pc    = tag_q[tag_rd_q];

  // Pop, push and bypass decisions. A redirect suppresses all three.
  always_comb begin
    pop    = !bus.redirect_valid && !bus.halt && !fifo_empty;
`ifdef IFETCH_BYPASS_EN
    bypass = !bus.redirect_valid && resp_fire && !drop_now && fifo_empty && !bus.halt;
`else
    bypass = 1'b0;
`endif
    push   = !bus.redirect_valid && resp_fire && !drop_now && !bypass;
  end

  // Next-state computation. A redirect overrides PC, flushes the FIFO and arms the drop counter.
  always_comb begin
    pc_d         = pc_q;
    fifo_cnt_d   = fifo_cnt_q;
    in_flight_d  = in_flight_q;
    drop_cnt_d   = drop_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    inst_d       = 8'h00;
    inst_pc_d    = '0;
    inst_valid_d = 1'b0;
    if (bus.redirect_valid) begin
      pc_d        = bus.redirect_pc;
      fifo_cnt_d  = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      // Every outstanding response is stale. One arriving this cycle is dropped right here.
      in_flight_d = in_flight_q - CW'(resp_fire);
      drop_cnt_d  = in_flight_q - CW'(resp_fire);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + ADDR_W'(1);
      end
      in_flight_d = in_flight_q + CW'(req_fire) - CW'(resp_fire);
      if (resp_fire && drop_now) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d     = rd_ptr_q + PW'(1);
        inst_d       = fifo_data_q[rd_ptr_q];
        inst_pc_d    = fifo_pc_q[rd_ptr_q];
        inst_valid_d = 1'b1;
      end else if (bypass) begin
        inst_d       = bus.imem_resp_data;
        inst_pc_d    = resp_pc;
        inst_valid_d = 1'b1;
      end
    end
    // Tag queue tracks every accepted request until its response returns, dropped or not
    tag_wr_d = tag_wr_q + PW'(req_fire);
    tag_rd_d = tag_rd_q + PW'(resp_fire);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= '0;
      fifo_cnt_q   <= '0;
      in_flight_q  <= '0;
      drop_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_wr_q     <= '0;
      tag_rd_q     <= '0;
      inst_q       <= 8'h00;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      fifo_cnt_q   <= fifo_cnt_d;
      in_flight_q  <= in_flight_d;
      drop_cnt_q   <= drop_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tag_wr_q     <= tag_wr_d;
      tag_rd_q     <= tag_rd_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // Data storage writes. Contents need no reset because the pointers and counters gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= bus.imem_resp_data;
      fifo_pc_q[wr_ptr_q]   <= resp_pc;
    end
    if (req_fire) begin
      tag_q[tag_wr_q] <= pc_q;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.inst_valid     = inst_valid_q;

endmodule

// File: tb/tb_inst_fetch_buf.sv
// tb_inst_fetch_buf: drives inst_fetch_buf against an in-order variable-latency memory model.
// A scoreboard queues {pc, data} when the memory returns a live response and compares
// when inst_valid shows it.
module tb_inst_fetch_buf;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;
`ifdef IFETCH_BYPASS_EN
  localparam int EXP_FIRST = 2;
`else
  localparam int EXP_FIRST = 3;
`endif

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                due;
    int                epoch;
  } pend_t;

  logic clk = 1'b0;
  logic rst;

  inst_fetch_buf_if #(.ADDR_W(ADDR_W)) bus ();

  inst_fetch_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- bench state ----------------
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  int          edge_n = 0;
  int          epoch = 0;
  int          lat = 1;
  int          n_valid = 0;
  int          fire_cnt = 0;
  int          first_valid_edge = -1;
  logic [7:0]  first_valid_inst;
  logic [7:0]  first_valid_pc;
  logic        s_req_valid;
  logic        s_fire;
  logic [7:0]  s_addr;
  logic        s_bubble;
  pend_t       pend_q[$];
  logic [15:0] exp_q[$];

  function automatic logic [7:0] mem_data(input logic [7:0] a);
    return a + 8'h40;
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic tick();
    logic [15:0] e;
    pend_t       p;
    @(negedge clk);
    s_req_valid = bus.imem_req_valid;
    s_fire      = bus.imem_req_valid && bus.imem_req_ready;
    s_addr      = bus.imem_req_addr;
    s_bubble    = rst || bus.halt || bus.redirect_valid;
    @(posedge clk);
    #1;
    edge_n++;
    if (s_fire) fire_cnt++;
    // scoreboard compare
    if (s_bubble) begin
      check("bubble_valid", 32'(bus.inst_valid), 0);
      check("bubble_word", {16'h0, bus.inst, bus.inst_pc}, 0);
    end else if (bus.inst_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_inst", 32'(bus.inst_valid), 0);
      end else begin
        e = exp_q.pop_front();
        check("inst_data", 32'(bus.inst), 32'(e[7:0]));
        check("inst_pc", 32'(bus.inst_pc), 32'(e[15:8]));
      end
    end else begin
      check("nop_word", {16'h0, bus.inst, bus.inst_pc}, 0);
    end
    if (bus.inst_valid) begin
      n_valid++;
      if (first_valid_edge < 0) begin
        first_valid_edge = edge_n;
        first_valid_inst = bus.inst;
        first_valid_pc   = bus.inst_pc;
      end
    end
    // memory model: log accepted request, then present the response due this cycle
    if (s_fire) pend_q.push_back('{addr: s_addr, due: cyc + lat, epoch: epoch});
    cyc++;
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_data(p.addr);
      if (p.epoch == epoch) exp_q.push_back({p.addr, mem_data(p.addr)});
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 8'h00;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 8'h00;
    bus.redirect_valid  = 1'b0;
    pend_q.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) tick();
    check("rst_req_valid", 32'(s_req_valid), 0);
    check("rst_now_req_valid", 32'(bus.imem_req_valid), 0);
    check("rst_inst_valid", 32'(bus.inst_valid), 0);
    check("rst_inst", 32'(bus.inst), 0);
    check("rst_inst_pc", 32'(bus.inst_pc), 0);
    rst = 1'b0;
    cyc = 0;
    edge_n = 0;
    n_valid = 0;
    fire_cnt = 0;
    first_valid_edge = -1;
  endtask

  task automatic redirect_to(input logic [7:0] a);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = a;
    epoch++;
    exp_q.delete();
    tick();
    bus.redirect_valid = 1'b0;
    n_valid = 0;
    fire_cnt = 0;
    first_valid_edge = -1;
  endtask

  // Stop issuing, let every outstanding response reach inst, then confirm nothing was lost
  task automatic drain();
    int guard;
    guard = 0;
    bus.imem_req_ready = 1'b0;
    while ((exp_q.size() != 0 || pend_q.size() != 0) && guard < 60) begin
      tick();
      guard++;
    end
    check("drain_left", 32'(exp_q.size() + pend_q.size()), 0);
    check("no_loss", 32'(n_valid), 32'(fire_cnt));
    bus.imem_req_ready = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] addrs[$];
    rst = 1'b1;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 8'h00;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.halt            = 1'b0;

    // 1: reset, then 1-cycle memory streams 0x40, 0x41, ... back to back
    lat = 1;
    do_reset(2);
    for (int i = 0; i < 10; i++) tick();
    check("first_valid_edge", 32'(first_valid_edge), EXP_FIRST);
    check("first_valid_inst", 32'(first_valid_inst), 32'h40);
    check("first_valid_pc", 32'(first_valid_pc), 0);
    check("stream_count", 32'(n_valid), 32'(10 - EXP_FIRST + 1));
    drain();

    // 2: latency 6 exhausts credits after DEPTH requests
    lat = 6;
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 4) check("credit_stall", 32'(s_req_valid), 0);
    end
    check("inflight_limit", 32'(fire_cnt), DEPTH);
    for (int i = 0; i < 40; i++) tick();
    check("lat6_has_bubbles", 32'(n_valid < 40), 1);
    drain();

    // 3: halt while the FIFO fills, then release and get all four in order
    lat = 1;
    bus.halt = 1'b1;
    do_reset(1);
    for (int i = 0; i < 8; i++) tick();
    check("halt_full_stall", 32'(s_req_valid), 0);
    check("halt_none_out", 32'(n_valid), 0);
    bus.halt = 1'b0;
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("halt_release_cnt", 32'(n_valid), 4);
    for (int i = 0; i < 2; i++) tick();
    check("halt_release_no_extra", 32'(n_valid), 4);
    drain();

    // 4: redirect with three requests in flight; stale data must vanish
    lat = 6;
    do_reset(1);
    for (int i = 0; i < 3; i++) tick();
    redirect_to(8'h80);
    tick();
    check("redir_req_fire", 32'(s_fire), 1);
    check("redir_req_addr", 32'(s_addr), 32'h80);
    for (int i = 0; i < 20; i++) tick();
    check("redir_first_pc", 32'(first_valid_pc), 32'h80);
    check("redir_first_inst", 32'(first_valid_inst), 32'(mem_data(8'h80)));
    drain();

    // 5: PC wrap after redirect to 0xFF
    lat = 1;
    redirect_to(8'hFF);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_fire) addrs.push_back(s_addr);
    end
    check("wrap_count_ok", 32'(addrs.size() >= 3), 1);
    if (addrs.size() >= 3) begin
      check("wrap_addr0", 32'(addrs[0]), 32'hFF);
      check("wrap_addr1", 32'(addrs[1]), 32'h00);
      check("wrap_addr2", 32'(addrs[2]), 32'h01);
    end
    check("wrap_first_pc", 32'(first_valid_pc), 32'hFF);
    drain();

    // 6: reset while the FIFO holds two entries, then restart cleanly from PC 0
    lat = 1;
    bus.halt = 1'b1;
    do_reset(1);
    for (int i = 0; i < 3; i++) tick();
    do_reset(1);
    bus.halt = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("post_rst_first_pc", 32'(first_valid_pc), 0);
    check("post_rst_first_inst", 32'(first_valid_inst), 32'h40);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
